// File: rtl/accel_seq_ctrl_pkg.sv
// Shared definitions for the accelerator sequencer: state encoding, activation
// select codes and phase-length helpers also used by the accelerator datapath.
package accel_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_W  = 3'd1,
    LOAD_A  = 3'd2,
    COMPUTE = 3'd3,
    DRAIN   = 3'd4,
    OUT     = 3'd5,
    POST    = 3'd6
  } state_t;

  localparam logic [1:0] ACT_NONE    = 2'b00;
  localparam logic [1:0] ACT_RELU    = 2'b01;
  localparam logic [1:0] ACT_SOFTMAX = 2'b10;

  function automatic int load_len(int array_h);
    return array_h;
  endfunction

  function automatic int compute_len(int array_w, int dsp_delay);
    return dsp_delay * array_w;
  endfunction

  // Last partial sum leaves the bottom row DSP_DELAY*(H-1) cycles late, then H rows drain.
  function automatic int drain_len(int array_h, int dsp_delay);
    return dsp_delay * (array_h - 1) + array_h;
  endfunction

  function automatic int max_phase_len(int array_h, int array_w, int dsp_delay, int act_lat);
    int m;
    m = load_len(array_h);
    if (compute_len(array_w, dsp_delay) > m) m = compute_len(array_w, dsp_delay);
    if (drain_len(array_h, dsp_delay) > m) m = drain_len(array_h, dsp_delay);
    if (act_lat > m) m = act_lat;
    return m;
  endfunction

endpackage

// File: rtl/accel_seq_ctrl_if.sv
// Command and accelerator-control bundle between host/DMA, the sequencer and the array.
interface accel_seq_ctrl_if #(
  parameter int ADDR_W = 4
);
  logic              start;
  logic              abort;
  logic [1:0]        act_sel;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] src_addr;
  logic              weight_buffer_load_en;
  logic              weight_buffer_out_en;
  logic              write_weight_en;
  logic              input_buffer_load_en;
  logic              input_buffer_out_en;
  logic              output_buffer_load_en;
  logic              output_buffer_out_en;
  logic              relu_en;
  logic              softmax_en;

  modport master (
    output start, abort, act_sel,
    input  busy, done, src_addr,
    input  weight_buffer_load_en, weight_buffer_out_en, write_weight_en,
    input  input_buffer_load_en, input_buffer_out_en,
    input  output_buffer_load_en, output_buffer_out_en,
    input  relu_en, softmax_en
  );

  modport slave (
    input  start, abort, act_sel,
    output busy, done, src_addr,
    output weight_buffer_load_en, weight_buffer_out_en, write_weight_en,
    output input_buffer_load_en, input_buffer_out_en,
    output output_buffer_load_en, output_buffer_out_en,
    output relu_en, softmax_en
  );
endinterface

// File: rtl/accel_phase_timer.sv
// Loadable down-counter timing one sequencer phase; last is high on the final phase cycle.
module accel_phase_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         last
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/accel_seq_ctrl.sv
// Single-tile sequencer for the systolic accelerator: one start produces the whole
// enable schedule plus source row addresses.
//
// state   | meaning
// IDLE    | waiting for start
// LOAD_W  | weight buffer fill, src_addr 0..H-1
// LOAD_A  | activation fill + weight preload, src_addr H..2H-1
// COMPUTE | array multiply-accumulate
// DRAIN   | partial sums into output buffer
// OUT     | output buffer readout
// POST    | activation enable hold
module accel_seq_ctrl
  import accel_seq_ctrl_pkg::*;
#(
  parameter int ARRAY_H   = 8,
  parameter int ARRAY_W   = 8,
  parameter int DSP_DELAY = 2,
  parameter int ACT_LAT   = 4
) (
  input  logic               clk,
  input  logic               rst,
  accel_seq_ctrl_if.slave    bus
);

  localparam int LEN_LOAD    = load_len(ARRAY_H);
  localparam int LEN_COMPUTE = compute_len(ARRAY_W, DSP_DELAY);
  localparam int LEN_DRAIN   = drain_len(ARRAY_H, DSP_DELAY);
  localparam int LEN_MAX     = max_phase_len(ARRAY_H, ARRAY_W, DSP_DELAY, ACT_LAT);
  localparam int CNT_W       = $clog2(LEN_MAX + 1);
  localparam int ADDR_W      = $clog2(2 * ARRAY_H);

  state_t            state, state_nxt;
  logic              phase_last;
  logic              phase_load;
  logic [CNT_W-1:0]  phase_val;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [1:0]        act_q;
  logic              accept;

  logic busy_q, done_q;
  logic wbuf_load_q, wbuf_out_q, write_weight_q;
  logic ibuf_load_q, ibuf_out_q;
  logic obuf_load_q, obuf_out_q;
  logic relu_q, softmax_q;

  assign accept = (state == IDLE) && bus.start && !bus.abort;

  accel_phase_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (phase_load),
    .load_val (phase_val),
    .last     (phase_last)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start)  state_nxt = LOAD_W;
      LOAD_W:  if (phase_last) state_nxt = LOAD_A;
      LOAD_A:  if (phase_last) state_nxt = COMPUTE;
      COMPUTE: if (phase_last) state_nxt = DRAIN;
      DRAIN:   if (phase_last) state_nxt = OUT;
      OUT:     if (phase_last) state_nxt = POST;
      POST:    if (phase_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.abort) state_nxt = IDLE;

    // Timer holds remaining cycles minus one so last coincides with the final phase cycle.
    phase_load = (state_nxt != state);
    case (state_nxt)
      LOAD_W, LOAD_A: phase_val = CNT_W'(LEN_LOAD - 1);
      COMPUTE:        phase_val = CNT_W'(LEN_COMPUTE - 1);
      DRAIN:          phase_val = CNT_W'(LEN_DRAIN - 1);
      POST:           phase_val = CNT_W'(ACT_LAT - 1);
      default:        phase_val = '0;
    endcase

    addr_nxt = '0;
    if (state_nxt == LOAD_W && state != LOAD_W) addr_nxt = '0;
    else if (state_nxt == LOAD_W || state_nxt == LOAD_A) addr_nxt = addr_q + ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act_q          <= ACT_NONE;
      addr_q         <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      wbuf_load_q    <= 1'b0;
      wbuf_out_q     <= 1'b0;
      write_weight_q <= 1'b0;
      ibuf_load_q    <= 1'b0;
      ibuf_out_q     <= 1'b0;
      obuf_load_q    <= 1'b0;
      obuf_out_q     <= 1'b0;
      relu_q         <= 1'b0;
      softmax_q      <= 1'b0;
    end else begin
      if (accept) act_q <= bus.act_sel;
      addr_q         <= addr_nxt;
      busy_q         <= (state_nxt != IDLE);
      done_q         <= (state == POST) && (state_nxt == IDLE) && !bus.abort;
      wbuf_load_q    <= (state_nxt == LOAD_W);
      wbuf_out_q     <= (state_nxt == LOAD_A);
      write_weight_q <= (state_nxt == LOAD_A);
      ibuf_load_q    <= (state_nxt == LOAD_A);
      ibuf_out_q     <= (state_nxt == COMPUTE) || (state_nxt == DRAIN) || (state_nxt == OUT);
      obuf_load_q    <= (state_nxt == DRAIN);
      obuf_out_q     <= (state_nxt == OUT);
      relu_q         <= ((state_nxt == OUT) || (state_nxt == POST)) && (act_q == ACT_RELU);
      softmax_q      <= ((state_nxt == OUT) || (state_nxt == POST)) && (act_q == ACT_SOFTMAX);
    end
  end

  assign bus.busy                  = busy_q;
  assign bus.done                  = done_q;
  assign bus.src_addr              = addr_q;
  assign bus.weight_buffer_load_en = wbuf_load_q;
  assign bus.weight_buffer_out_en  = wbuf_out_q;
  assign bus.write_weight_en       = write_weight_q;
  assign bus.input_buffer_load_en  = ibuf_load_q;
  assign bus.input_buffer_out_en   = ibuf_out_q;
  assign bus.output_buffer_load_en = obuf_load_q;
  assign bus.output_buffer_out_en  = obuf_out_q;
  assign bus.relu_en               = relu_q;
  assign bus.softmax_en            = softmax_q;

endmodule

// File: tb/tb_accel_seq_ctrl.sv
// Bench for accel_seq_ctrl: default and reduced-size instances share stimulus and are
// compared every cycle against a tile-cycle-index model.
module tb_accel_seq_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic start, abort;
  logic [1:0] act_sel;

  always #5 clk = ~clk;

  accel_seq_ctrl_if #(.ADDR_W(4)) bus0 ();
  accel_seq_ctrl_if #(.ADDR_W(3)) bus1 ();

  assign bus0.start = start;
  assign bus0.abort = abort;
  assign bus0.act_sel = act_sel;
  assign bus1.start = start;
  assign bus1.abort = abort;
  assign bus1.act_sel = act_sel;

  accel_seq_ctrl #(.ARRAY_H(8), .ARRAY_W(8), .DSP_DELAY(2), .ACT_LAT(4)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0));
  accel_seq_ctrl #(.ARRAY_H(4), .ARRAY_W(4), .DSP_DELAY(1), .ACT_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1));

  typedef struct {
    int         t;     // 0 = idle, else 1-based cycle within the tile
    bit         done;
    logic [1:0] act;
  } mdl_t;

  mdl_t m0, m1;
  int errors = 0;
  int checks = 0;
  int cyc_n  = 0;
  int blen0  = 0;
  int blen1  = 0;

  function automatic int tile_len(int h, int w, int d, int a);
    return 2*h + d*w + d*(h-1) + h + 1 + a;
  endfunction

  function automatic mdl_t step(mdl_t m, int total, bit r, bit s, bit a, logic [1:0] sel);
    mdl_t n = m;
    n.done = 1'b0;
    if (r) begin
      n.t = 0; n.act = 2'b00;
    end else if (a) begin
      n.t = 0;
    end else if (m.t == 0 && s) begin
      n.t = 1; n.act = sel;
    end else if (m.t == total) begin
      n.t = 0; n.done = 1'b1;
    end else if (m.t != 0) begin
      n.t = m.t + 1;
    end
    return n;
  endfunction

  function automatic logic [14:0] exp_vec(mdl_t m, int h, int w, int d, int a);
    int t  = m.t;
    int e1 = h;
    int e2 = 2*h;
    int e3 = e2 + d*w;
    int e4 = e3 + d*(h-1) + h;
    int e5 = e4 + 1;
    logic busy, ldw, lda, ibo, obl, obo, post;
    logic [3:0] addr;
    busy = (t != 0);
    ldw  = (t >= 1) && (t <= e1);
    lda  = (t > e1) && (t <= e2);
    addr = (ldw || lda) ? 4'(t - 1) : 4'd0;
    ibo  = (t > e2) && (t <= e5);
    obl  = (t > e3) && (t <= e4);
    obo  = (t == e5);
    post = (t >= e5) && (t <= e5 + a);
    return {busy, m.done, addr, ldw, lda, lda, lda, ibo, obl, obo,
            post && (m.act == 2'b01), post && (m.act == 2'b10)};
  endfunction

  task automatic check_vec(string tag, logic [14:0] obs, logic [14:0] ex);
    checks++;
    assert (obs === ex) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc_n, obs, ex);
    end
  endtask

  task automatic check_int(string tag, int obs, int ex);
    checks++;
    assert (obs === ex) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc_n, obs, ex);
    end
  endtask

  task automatic cyc(bit r, bit s, bit a, logic [1:0] sel);
    logic [14:0] o0, o1;
    rst = r; start = s; abort = a; act_sel = sel;
    @(posedge clk);
    m0 = step(m0, tile_len(8, 8, 2, 4), r, s, a, sel);
    m1 = step(m1, tile_len(4, 4, 1, 1), r, s, a, sel);
    #1;
    cyc_n++;
    o0 = {bus0.busy, bus0.done, bus0.src_addr, bus0.weight_buffer_load_en,
          bus0.weight_buffer_out_en, bus0.write_weight_en, bus0.input_buffer_load_en,
          bus0.input_buffer_out_en, bus0.output_buffer_load_en, bus0.output_buffer_out_en,
          bus0.relu_en, bus0.softmax_en};
    o1 = {bus1.busy, bus1.done, 1'b0, bus1.src_addr, bus1.weight_buffer_load_en,
          bus1.weight_buffer_out_en, bus1.write_weight_en, bus1.input_buffer_load_en,
          bus1.input_buffer_out_en, bus1.output_buffer_load_en, bus1.output_buffer_out_en,
          bus1.relu_en, bus1.softmax_en};
    check_vec("dut0_outputs", o0, exp_vec(m0, 8, 8, 2, 4));
    check_vec("dut1_outputs", o1, exp_vec(m1, 4, 4, 1, 1));
    // Completed tiles must have been busy for exactly the documented tile length.
    if (bus0.done) check_int("dut0_busy_len", blen0, 59);
    if (bus1.done) check_int("dut1_busy_len", blen1, 21);
    blen0 = bus0.busy ? blen0 + 1 : 0;
    blen1 = bus1.busy ? blen1 + 1 : 0;
  endtask

  initial begin
    m0 = '{t: 0, done: 1'b0, act: 2'b00};
    m1 = '{t: 0, done: 1'b0, act: 2'b00};

    cyc(1, 1, 0, 2'b10);
    cyc(1, 0, 0, 2'b10);

    // Softmax tile with starts while busy, then a start in the done cycle selecting relu.
    cyc(0, 1, 0, 2'b10);
    for (int i = 1; i <= 125; i++)
      cyc(0, (i == 5) || (i == 40) || (i == 60), 0,
          (i == 60) ? 2'b01 : 2'($urandom_range(0, 3)));
    cyc(0, 0, 0, 2'b00);

    // Abort in COMPUTE, then a clean tile with act_sel 11.
    cyc(0, 1, 0, 2'($urandom_range(0, 3)));
    for (int i = 1; i <= 30; i++) cyc(0, 0, (i == 20), 2'($urandom_range(0, 3)));
    cyc(0, 1, 0, 2'b11);
    for (int i = 1; i <= 62; i++) cyc(0, 0, 0, 2'($urandom_range(0, 3)));

    // Reset mid-DRAIN.
    cyc(0, 1, 0, 2'b01);
    for (int i = 1; i <= 50; i++) cyc((i == 45), 0, 0, 2'b01);

    // Abort beats start in IDLE, abort alone in IDLE does nothing.
    cyc(0, 1, 1, 2'b01);
    cyc(0, 0, 1, 2'b01);
    cyc(0, 0, 0, 2'b00);

    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 5) == 0,
          $urandom_range(0, 49) == 0, 2'($urandom_range(0, 3)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
